// File: rtl/stream_mux_nto1_pkg.sv
// Shared constants and helpers for the N-to-1 streaming multiplexer.
package stream_mux_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  // Channel-index width; a single channel still needs one bit.
  function automatic int sel_width(input int ch);
    return (ch > 1) ? $clog2(ch) : 1;
  endfunction

endpackage

// File: rtl/stream_mux_nto1_if.sv
// Handshake bundle: CH input channels, select controls and the registered output.
interface stream_mux_nto1_if
  import stream_mux_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CH    = 16
);
  localparam int SELW = sel_width(CH);

  logic [CH*WIDTH-1:0] in_data;
  logic [CH-1:0]       in_valid;
  logic [CH-1:0]       in_ready;
  logic                mode;
  logic [SELW-1:0]     sel;
  logic [WIDTH-1:0]    out_data;
  logic [SELW-1:0]     out_ch;
  logic                out_valid;
  logic                out_ready;

  modport master (
    output in_data, in_valid, mode, sel, out_ready,
    input  in_ready, out_data, out_ch, out_valid
  );

  modport slave (
    input  in_data, in_valid, mode, sel, out_ready,
    output in_ready, out_data, out_ch, out_valid
  );

endinterface

// File: rtl/stream_mux_nto1_rr_arbiter.sv
// Combinational round-robin pick: first requester after 'last', wrapping modulo CH.
module rr_arbiter
  import stream_mux_pkg::*;
#(
  parameter int CH   = 16,
  parameter int SELW = sel_width(CH)
) (
  input  logic [CH-1:0]   req,
  input  logic [SELW-1:0] last,
  output logic [SELW-1:0] grant,
  output logic            gvalid
);

  int w_idx;

  always_comb begin
    grant  = '0;
    gvalid = 1'b0;
    w_idx  = 0;
    for (int k = 1; k <= CH; k++) begin
      w_idx = (int'(last) + k) % CH;
      if (!gvalid && req[w_idx]) begin
        gvalid = 1'b1;
        grant  = SELW'(w_idx);
      end
    end
  end

endmodule

// File: rtl/stream_mux_nto1.sv
// N-to-1 valid/ready mux with fixed or round-robin selection and one registered output stage.
module stream_mux_nto1
  import stream_mux_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CH    = 16
) (
  input logic              clk,
  input logic              rst_n,
  stream_mux_nto1_if.slave bus
);

  localparam int SELW = sel_width(CH);

  logic [WIDTH-1:0] r_out_data;
  logic [SELW-1:0]  r_out_ch;
  logic             r_out_valid;
  logic [SELW-1:0]  r_last;

  logic             w_load;
  logic [SELW-1:0]  w_rr_grant;
  logic             w_rr_gvalid;
  logic             w_fix_gvalid;
  logic [SELW-1:0]  w_grant;
  logic             w_gvalid;
  logic [WIDTH-1:0] w_data;
  logic [CH-1:0]    w_in_ready;

  rr_arbiter #(.CH(CH), .SELW(SELW)) u_rr_arbiter (
    .req    (bus.in_valid),
    .last   (r_last),
    .grant  (w_rr_grant),
    .gvalid (w_rr_gvalid)
  );

  assign w_load = !r_out_valid || bus.out_ready;

  // Select values with no matching channel (non-power-of-2 CH) never match, so gvalid stays low.
  always_comb begin
    w_fix_gvalid = 1'b0;
    for (int i = 0; i < CH; i++) begin
      if (bus.sel == SELW'(i)) w_fix_gvalid = bus.in_valid[i];
    end
  end

  assign w_grant  = (bus.mode == MODE_RR) ? w_rr_grant  : bus.sel;
  assign w_gvalid = (bus.mode == MODE_RR) ? w_rr_gvalid : w_fix_gvalid;

  always_comb begin
    w_data     = '0;
    w_in_ready = '0;
    for (int i = 0; i < CH; i++) begin
      if (w_grant == SELW'(i)) begin
        w_data        = bus.in_data[i*WIDTH +: WIDTH];
        w_in_ready[i] = w_load && w_gvalid && rst_n;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_data  <= '0;
      r_out_ch    <= '0;
      r_out_valid <= 1'b0;
      r_last      <= SELW'(CH - 1);
    end else if (w_load) begin
      if (w_gvalid) begin
        r_out_data  <= w_data;
        r_out_ch    <= w_grant;
        r_out_valid <= 1'b1;
        if (bus.mode == MODE_RR) r_last <= w_grant;
      end else begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_data  = r_out_data;
  assign bus.out_ch    = r_out_ch;
  assign bus.out_valid = r_out_valid;

endmodule

// File: tb/tb_stream_mux_nto1.sv
// Randomised scoreboard bench for stream_mux_nto1 (CH=16) plus a CH=12 out-of-range select instance.
module tb_stream_mux_nto1;
  import stream_mux_pkg::*;

  localparam int W  = 8;
  localparam int CH = 16;

  logic clk = 1'b0;
  logic rst_n;

  stream_mux_nto1_if #(.WIDTH(W), .CH(CH)) bus ();
  stream_mux_nto1_if #(.WIDTH(W), .CH(12)) bus12 ();

  stream_mux_nto1 #(.WIDTH(W), .CH(CH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  stream_mux_nto1 #(.WIDTH(W), .CH(12)) dut12 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus12)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] d;
    int         ch;
  } beat_t;

  beat_t       q[$];
  int          n_vec = 0;
  int          n_err = 0;
  bit          m_ov;
  int          m_last;
  logic [15:0] rdy_s;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference selection computed straight from the select rules.
  function automatic void model_grant(input logic [15:0] v, input logic md, input int s,
                                      input int last, output int g, output bit gv);
    gv = 0;
    g  = 0;
    if (md == MODE_FIXED) begin
      g  = s;
      gv = (s < CH) && v[s];
    end else begin
      for (int k = 1; k <= CH; k++) begin
        int c;
        c = (last + k) % CH;
        if (!gv && v[c]) begin
          gv = 1;
          g  = c;
        end
      end
    end
  endfunction

  task automatic rand_data();
    for (int c = 0; c < CH; c++) bus.in_data[c*W +: W] = 8'($urandom);
    for (int c = 0; c < 12; c++) bus12.in_data[c*W +: W] = 8'($urandom);
  endtask

  task automatic model_reset();
    q.delete();
    m_ov   = 0;
    m_last = CH - 1;
  endtask

  // One clock cycle: predict, compare, push expected beat, advance to 2 units after the edge.
  task automatic step();
    int          g;
    bit          gv;
    bit          mload;
    logic [15:0] exp_rdy;
    beat_t       b;
    #1;
    rdy_s = bus.in_ready;
    if (!rst_n) begin
      chk("in_ready_rst", bus.in_ready, 0);
      chk("out_valid_rst", bus.out_valid, 0);
    end else begin
      model_grant(bus.in_valid, bus.mode, int'(bus.sel), m_last, g, gv);
      mload   = !m_ov || bus.out_ready;
      exp_rdy = (mload && gv) ? (16'h1 << g) : 16'h0;
      chk("in_ready", bus.in_ready, exp_rdy);
      chk("out_valid", bus.out_valid, m_ov);
      if (mload) begin
        if (gv) begin
          b.d  = bus.in_data[g*W +: W];
          b.ch = g;
          q.push_back(b);
          m_ov = 1;
          if (bus.mode == MODE_RR) m_last = g;
        end else begin
          m_ov = 0;
        end
      end
    end
    @(posedge clk);
    #2;
  endtask

  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      if (q.size() == 0) begin
        chk("unexpected_beat", 32'(bus.out_ch), 32'hFFFF_FFFF);
      end else begin
        beat_t b;
        b = q.pop_front();
        chk("out_data", bus.out_data, b.d);
        chk("out_ch", bus.out_ch, b.ch);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] held;
    int         exp_seq [4] = '{1, 2, 4, 5};

    rst_n           = 1'b0;
    bus.in_valid    = '1;
    bus.mode        = MODE_RR;
    bus.sel         = '0;
    bus.out_ready   = 1'b1;
    bus12.in_valid  = '1;
    bus12.mode      = MODE_FIXED;
    bus12.sel       = 4'd13;
    bus12.out_ready = 1'b1;
    rand_data();
    model_reset();

    #12;
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_data", bus.out_data, 0);
    chk("rst_out_ch", bus.out_ch, 0);
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_in_ready12", bus12.in_ready, 0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;

    // Round-robin with everyone valid: 0..15 then wrap to 0, no bubbles.
    for (int i = 0; i <= 16; i++) begin
      rand_data();
      step();
      chk("rr_seq_ch", bus.out_ch, i % 16);
      chk("rr_seq_valid", bus.out_valid, 1);
    end
    bus.in_valid = 16'hFFF7;
    for (int i = 0; i < 4; i++) begin
      rand_data();
      step();
      chk("rr_skip3_ch", bus.out_ch, exp_seq[i]);
    end

    // Backpressure on a channel-7 beat.
    bus.in_valid = '1;
    bus.mode     = MODE_FIXED;
    bus.sel      = 4'd7;
    rand_data();
    step();
    chk("bp_load_ch", bus.out_ch, 7);
    held          = bus.out_data;
    bus.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      rand_data();
      bus.sel = 4'($urandom_range(0, 15));
      step();
      chk("bp_hold_ch", bus.out_ch, 7);
      chk("bp_hold_data", bus.out_data, held);
      chk("bp_hold_valid", bus.out_valid, 1);
      chk("bp_in_ready", rdy_s, 0);
    end
    bus.out_ready = 1'b1;
    bus.sel       = 4'd8;
    step();
    chk("bp_replace_ch", bus.out_ch, 8);
    chk("bp_replace_valid", bus.out_valid, 1);

    // Fixed select on channel 5.
    bus.sel                 = 4'd5;
    bus.in_data[5*W +: W]   = 8'hA5;
    step();
    chk("fix_in_ready", rdy_s, 16'h0020);
    chk("fix_out_data", bus.out_data, 8'hA5);
    chk("fix_out_ch", bus.out_ch, 5);

    // Drain.
    bus.in_valid = '0;
    step();
    chk("drain_valid", bus.out_valid, 0);
    step();
    chk("drain_valid2", bus.out_valid, 0);

    // CH=12 with out-of-range select, then a legal one.
    chk("ch12_in_ready", bus12.in_ready, 0);
    chk("ch12_out_valid", bus12.out_valid, 0);
    bus12.sel = 4'd11;
    #1;
    chk("ch12_sel11_ready", bus12.in_ready, 12'h800);
    @(posedge clk);
    #1;
    chk("ch12_sel11_ch", bus12.out_ch, 11);
    chk("ch12_sel11_valid", bus12.out_valid, 1);
    #1;
    bus12.sel = 4'd13;

    // Randomised traffic with mode/sel changes and backpressure.
    for (int i = 0; i < 400; i++) begin
      rand_data();
      case ($urandom_range(0, 3))
        0:       bus.in_valid = '1;
        1:       bus.in_valid = 16'(1 << $urandom_range(0, 15));
        default: bus.in_valid = 16'($urandom & $urandom);
      endcase
      if ($urandom_range(0, 7) == 0) bus.mode = ~bus.mode;
      bus.sel       = 4'($urandom_range(0, 15));
      bus.out_ready = ($urandom_range(0, 3) != 0);
      step();
    end

    // Asynchronous reset while a beat is held.
    bus.mode      = MODE_RR;
    bus.in_valid  = '1;
    bus.out_ready = 1'b1;
    step();
    step();
    chk("arst_pre_valid", bus.out_valid, 1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", bus.out_valid, 0);
    chk("arst_out_data", bus.out_data, 0);
    chk("arst_out_ch", bus.out_ch, 0);
    chk("arst_in_ready", bus.in_ready, 0);
    model_reset();
    step();
    step();
    rst_n = 1'b1;
    step();
    chk("arst_restart_ch", bus.out_ch, 0);
    chk("arst_restart_valid", bus.out_valid, 1);
    bus.in_valid = '0;
    step();
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
